// File: rtl/inst_fifo_writer.sv
// rtl/inst_fifo_writer.sv - pairs 32-bit bus writes into 64-bit sequencer instructions, owns start controls and result reads (optional stall counter: INST_FIFO_WRITER_STATS_EN)
module inst_fifo_writer #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int RESULT_WIDTH   = 32,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          bus_wr_valid,
  input  logic [BUS_DATA_WIDTH-1:0]     bus_wr_data,
  output logic                          bus_wr_ready,
  input  logic                          ctrl_valid,
  input  logic [3:0]                    ctrl_data,
  input  logic                          inst_fifo_full,
  output logic                          inst_fifo_wr_en,
  output logic [2*BUS_DATA_WIDTH-1:0]   inst_fifo_wr_data,
  output logic                          pulse_controller_hold,
  output logic                          pulse_controller_release,
  output logic                          init,
  input  logic                          bus_rd_req,
  input  logic                          result_fifo_empty,
  output logic                          result_fifo_rd_en,
  input  logic [RESULT_WIDTH-1:0]       result_fifo_rd_data,
  output logic [RESULT_WIDTH-1:0]       bus_rd_data,
  output logic                          bus_rd_valid,
  output logic                          half_pending,
  output logic [CNT_WIDTH-1:0]          inst_count
`ifdef INST_FIFO_WRITER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]          stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

  state_t                     state, state_next;
  logic [BUS_DATA_WIDTH-1:0]  lo_word, hi_word;
  logic                       full_cond, full_cond_q;
  logic                       rd_valid_q, rd_empty_q;

  logic ctrl_set_hold, ctrl_clr_hold, ctrl_release, ctrl_init;
  assign ctrl_set_hold = ctrl_valid & ctrl_data[0];
  assign ctrl_clr_hold = ctrl_valid & ctrl_data[1];
  assign ctrl_release  = ctrl_valid & ctrl_data[2];
  assign ctrl_init     = ctrl_valid & ctrl_data[3];

  // The bus is stalled only while a complete instruction waits for the FIFO.
  assign bus_wr_ready = (state != ST_PEND);
  assign half_pending = (state == ST_HALF);
  assign full_cond    = (state == ST_PEND) && inst_fifo_full;

  // First bus word goes to the MSBs: the FIFO presents MSB-first and the sequencer swaps halves.
  assign inst_fifo_wr_data = {lo_word, hi_word};

  // State register for the half-word assembler.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_next;
  end

  // Next-state and push strobe; init discards any partial or pending instruction.
  always_comb begin
    state_next      = state;
    inst_fifo_wr_en = 1'b0;
    case (state)
      ST_EMPTY: if (bus_wr_valid) state_next = ST_HALF;
      ST_HALF:  if (bus_wr_valid) state_next = ST_PEND;
      ST_PEND: begin
        if (!inst_fifo_full) begin
          inst_fifo_wr_en = 1'b1;
          state_next      = ST_EMPTY;
        end
      end
      default:  state_next = ST_EMPTY;
    endcase
    if (ctrl_init) begin
      state_next      = ST_EMPTY;
      inst_fifo_wr_en = 1'b0;
    end
  end

  // Capture the two halves as they are accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lo_word <= '0;
      hi_word <= '0;
    end else if (bus_wr_valid && state == ST_EMPTY) begin
      lo_word <= bus_wr_data;
    end else if (bus_wr_valid && state == ST_HALF) begin
      hi_word <= bus_wr_data;
    end
  end

  // Instruction counter, zeroed by init, wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                inst_count <= '0;
    else if (ctrl_init)       inst_count <= '0;
    else if (inst_fifo_wr_en) inst_count <= inst_count + CNT_WIDTH'(1);
  end

  // Hold level; a simultaneous clear beats set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)              pulse_controller_hold <= 1'b0;
    else if (ctrl_clr_hold) pulse_controller_hold <= 1'b0;
    else if (ctrl_set_hold) pulse_controller_hold <= 1'b1;
  end

  // Release/init pulses; a FIFO that fills while an instruction waits auto-releases so it drains.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_controller_release <= 1'b0;
      init                     <= 1'b0;
      full_cond_q              <= 1'b0;
    end else begin
      pulse_controller_release <= ctrl_release | (full_cond & ~full_cond_q);
      init                     <= ctrl_init;
      full_cond_q              <= full_cond;
    end
  end

  // Result path: pop now, present FIFO data (or the empty marker) next cycle.
  assign result_fifo_rd_en = bus_rd_req & ~result_fifo_empty;
  assign bus_rd_valid      = rd_valid_q;
  assign bus_rd_data       = !rd_valid_q ? '0 :
                             rd_empty_q  ? '1 : result_fifo_rd_data;

  // Track which read was issued last cycle and whether it found the FIFO empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_empty_q <= 1'b0;
    end else begin
      rd_valid_q <= bus_rd_req;
      rd_empty_q <= bus_rd_req & result_fifo_empty;
    end
  end

`ifdef INST_FIFO_WRITER_STATS_EN
  // Saturating count of cycles spent blocked on a full FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               stall_cycles <= '0;
    else if (ctrl_init)                      stall_cycles <= '0;
    else if (full_cond && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_inst_fifo_writer.sv
// tb/tb_inst_fifo_writer.sv - directed self-checking bench for inst_fifo_writer
module tb_inst_fifo_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bus_wr_valid = 1'b0;
  logic [31:0] bus_wr_data = '0;
  logic        bus_wr_ready;
  logic        ctrl_valid = 1'b0;
  logic [3:0]  ctrl_data = '0;
  logic        inst_fifo_full = 1'b0;
  logic        inst_fifo_wr_en;
  logic [63:0] inst_fifo_wr_data;
  logic        pulse_controller_hold;
  logic        pulse_controller_release;
  logic        init;
  logic        bus_rd_req = 1'b0;
  logic        result_fifo_empty;
  logic        result_fifo_rd_en;
  logic [31:0] result_fifo_rd_data = '0;
  logic [31:0] bus_rd_data;
  logic        bus_rd_valid;
  logic        half_pending;
  logic [31:0] inst_count;
`ifdef INST_FIFO_WRITER_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] res_mem [0:1];
  int          res_rd = 2;

  always #5 clock = ~clock;

  assign result_fifo_empty = (res_rd >= 2);

  always @(posedge clock) begin
    if (result_fifo_rd_en && res_rd < 2) begin
      result_fifo_rd_data <= res_mem[res_rd];
      res_rd <= res_rd + 1;
    end
  end

  inst_fifo_writer dut (
    .clock                    (clock),
    .reset                    (reset),
    .bus_wr_valid             (bus_wr_valid),
    .bus_wr_data              (bus_wr_data),
    .bus_wr_ready             (bus_wr_ready),
    .ctrl_valid               (ctrl_valid),
    .ctrl_data                (ctrl_data),
    .inst_fifo_full           (inst_fifo_full),
    .inst_fifo_wr_en          (inst_fifo_wr_en),
    .inst_fifo_wr_data        (inst_fifo_wr_data),
    .pulse_controller_hold    (pulse_controller_hold),
    .pulse_controller_release (pulse_controller_release),
    .init                     (init),
    .bus_rd_req               (bus_rd_req),
    .result_fifo_empty        (result_fifo_empty),
    .result_fifo_rd_en        (result_fifo_rd_en),
    .result_fifo_rd_data      (result_fifo_rd_data),
    .bus_rd_data              (bus_rd_data),
    .bus_rd_valid             (bus_rd_valid),
    .half_pending             (half_pending),
    .inst_count               (inst_count)
`ifdef INST_FIFO_WRITER_STATS_EN
    ,
    .stall_cycles             (stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's stimulus point; outputs settle by #1.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int rel_seen;

    res_mem[0] = 32'hDEADBEEF;
    res_mem[1] = 32'h00000005;

    repeat (2) step();
    reset = 1'b0;
    settle();
    check("rst_ready", bus_wr_ready, 1);
    check("rst_wr_en", inst_fifo_wr_en, 0);
    check("rst_hold", pulse_controller_hold, 0);
    check("rst_release", pulse_controller_release, 0);
    check("rst_init", init, 0);
    check("rst_count", inst_count, 0);
    check("rst_half", half_pending, 0);
    check("rst_rd_valid", bus_rd_valid, 0);
    check("rst_rd_data", bus_rd_data, 0);

    // Basic pair: 0x11111111 then 0x22222222.
    step(); bus_wr_valid = 1; bus_wr_data = 32'h11111111;
    settle(); check("t1_ready0", bus_wr_ready, 1);
    step(); bus_wr_data = 32'h22222222;
    settle(); check("t1_half", half_pending, 1);
    check("t1_ready1", bus_wr_ready, 1);
    step(); bus_wr_valid = 0;
    settle(); check("t1_wr_en", inst_fifo_wr_en, 1);
    check("t1_wr_data", inst_fifo_wr_data, 64'h1111111122222222);
    check("t1_ready_low", bus_wr_ready, 0);
    step(); settle();
    check("t1_wr_en_off", inst_fifo_wr_en, 0);
    check("t1_ready_back", bus_wr_ready, 1);
    check("t1_count", inst_count, 1);

    // FIFO full before the second word: stall, one release pulse, push once full drops.
    step(); bus_wr_valid = 1; bus_wr_data = 32'hCAFE0001;
    step(); bus_wr_data = 32'hCAFE0002; inst_fifo_full = 1;
    rel_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(); bus_wr_valid = 0;
      settle();
      check("t2_no_push", inst_fifo_wr_en, 0);
      check("t2_stall_ready", bus_wr_ready, 0);
      if (pulse_controller_release) rel_seen++;
    end
    step(); inst_fifo_full = 0;
    settle();
    if (pulse_controller_release) rel_seen++;
    check("t2_release_count", rel_seen, 1);
    check("t2_push", inst_fifo_wr_en, 1);
    check("t2_data", inst_fifo_wr_data, 64'hCAFE0001CAFE0002);
`ifdef INST_FIFO_WRITER_STATS_EN
    check("t2_stall_cycles", stall_cycles, 10);
`endif
    step(); settle();
    check("t2_count", inst_count, 2);

    // One half then init: pulse, partial word dropped, count cleared.
    step(); bus_wr_valid = 1; bus_wr_data = 32'hAAAA0000;
    step(); bus_wr_valid = 0; ctrl_valid = 1; ctrl_data = 4'h8;
    settle(); check("t3_half_before", half_pending, 1);
    step(); ctrl_valid = 0; ctrl_data = 4'h0;
    settle();
    check("t3_init_pulse", init, 1);
    check("t3_half_cleared", half_pending, 0);
    check("t3_no_push", inst_fifo_wr_en, 0);
    check("t3_count_zero", inst_count, 0);
    step(); settle();
    check("t3_init_off", init, 0);
    check("t3_no_push2", inst_fifo_wr_en, 0);
    bus_wr_valid = 1; bus_wr_data = 32'h33333333;
    step(); bus_wr_data = 32'h44444444;
    step(); bus_wr_valid = 0;
    settle();
    check("t3_push", inst_fifo_wr_en, 1);
    check("t3_data", inst_fifo_wr_data, 64'h3333333344444444);
    step(); settle();
    check("t3_count", inst_count, 1);

    // Init coincident with the second word drops it.
    bus_wr_valid = 1; bus_wr_data = 32'h55555555;
    step(); bus_wr_data = 32'h66666666; ctrl_valid = 1; ctrl_data = 4'h8;
    step(); bus_wr_valid = 0; ctrl_valid = 0; ctrl_data = 4'h0;
    settle();
    check("t3b_no_push", inst_fifo_wr_en, 0);
    check("t3b_ready", bus_wr_ready, 1);
    check("t3b_half", half_pending, 0);

    // Hold set, then set+clear together: clear wins.
    step(); ctrl_valid = 1; ctrl_data = 4'h1;
    step(); ctrl_valid = 0; ctrl_data = 4'h0;
    settle(); check("t4_hold_set", pulse_controller_hold, 1);
    step(); ctrl_valid = 1; ctrl_data = 4'h3;
    step(); ctrl_valid = 0; ctrl_data = 4'h0;
    settle(); check("t4_hold_clr", pulse_controller_hold, 0);

    // Release and init in one control write: both pulse together for one cycle.
    step(); ctrl_valid = 1; ctrl_data = 4'hC;
    step(); ctrl_valid = 0; ctrl_data = 4'h0;
    settle();
    check("t4_rel_pulse", pulse_controller_release, 1);
    check("t4_init_pulse", init, 1);
    step(); settle();
    check("t4_rel_off", pulse_controller_release, 0);
    check("t4_init_off", init, 0);

    // Result reads: two back-to-back pops then an empty read.
    res_rd = 0;
    step(); bus_rd_req = 1;
    settle(); check("t5_rd_en0", result_fifo_rd_en, 1);
    check("t5_valid_none", bus_rd_valid, 0);
    step(); settle();
    check("t5_rd_en1", result_fifo_rd_en, 1);
    check("t5_valid1", bus_rd_valid, 1);
    check("t5_data1", bus_rd_data, 32'hDEADBEEF);
    step(); settle();
    check("t5_rd_en_empty", result_fifo_rd_en, 0);
    check("t5_valid2", bus_rd_valid, 1);
    check("t5_data2", bus_rd_data, 32'h00000005);
    step(); bus_rd_req = 0;
    settle();
    check("t5_valid3", bus_rd_valid, 1);
    check("t5_empty_marker", bus_rd_data, 32'hFFFFFFFF);
    check("t5_no_pop", result_fifo_rd_en, 0);
    step(); settle();
    check("t5_idle_valid", bus_rd_valid, 0);
    check("t5_idle_data", bus_rd_data, 0);

    // Reset in PEND with the FIFO full.
    ctrl_valid = 1; ctrl_data = 4'h1;
    step(); ctrl_valid = 0; ctrl_data = 4'h0;
    bus_wr_valid = 1; bus_wr_data = 32'h77777777;
    step(); bus_wr_data = 32'h88888888; inst_fifo_full = 1;
    step(); bus_wr_valid = 0;
    step(); settle();
    check("t6_pend_ready", bus_wr_ready, 0);
    reset = 1;
    settle();
    check("t6_rst_ready", bus_wr_ready, 1);
    check("t6_rst_wr_en", inst_fifo_wr_en, 0);
    check("t6_rst_hold", pulse_controller_hold, 0);
    check("t6_rst_half", half_pending, 0);
    check("t6_rst_release", pulse_controller_release, 0);
`ifdef INST_FIFO_WRITER_STATS_EN
    check("t6_rst_stall", stall_cycles, 0);
`endif
    step(); reset = 0; inst_fifo_full = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t6_no_push", inst_fifo_wr_en, 0);
      step();
    end
    check("t6_count", inst_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fifo_writer.md
Name: inst_fifo_writer

Overview:
- Bus-side producer for the pulse sequencer's 64-bit instruction FIFO.
- Accepts 32-bit bus writes, pairs them into 64-bit instruction words and pushes them into the FIFO with the word order the sequencer expects. It stalls the bus when the FIFO is full.
- Owns the sequencer start controls: hold, release and init.
- Also pops the result FIFO for bus reads.
- Sits between the AXI slave register decode and the instruction/result FIFOs.

Parameters:
- BUS_DATA_WIDTH, 32, bus word width; the instruction word is 2x this.
- RESULT_WIDTH, 32, result FIFO data width.
- CNT_WIDTH, 32, width of the instruction and stall counters.

Ports:
- clock  in  1  system clock
- reset  in  1  async, active-high
- bus_wr_valid  in  1  bus write of an instruction half-word
- bus_wr_data  in  BUS_DATA_WIDTH  half-word data
- bus_wr_ready  out  1  write accepted this cycle when valid&ready
- ctrl_valid  in  1  control write strobe
- ctrl_data  in  4  bit0 set_hold, bit1 clr_hold, bit2 release, bit3 init
- inst_fifo_full  in  1  instruction FIFO full
- inst_fifo_wr_en  out  1  push strobe
- inst_fifo_wr_data  out  2*BUS_DATA_WIDTH  pushed word
- pulse_controller_hold  out  1  sequencer hold level
- pulse_controller_release  out  1  one-cycle release pulse
- init  out  1  one-cycle sequencer init pulse
- bus_rd_req  in  1  bus read request for the result FIFO
- result_fifo_empty  in  1  result FIFO empty
- result_fifo_rd_en  out  1  pop strobe
- result_fifo_rd_data  in  RESULT_WIDTH  FIFO data, valid 1 cycle after rd_en
- bus_rd_data  out  RESULT_WIDTH  read data
- bus_rd_valid  out  1  read data valid
- half_pending  out  1  low half latched, high half outstanding
- inst_count  out  CNT_WIDTH  instructions pushed since reset/init

Behaviour:
- Reset (async): state EMPTY, all strobes 0, bus_wr_ready 1, pulse_controller_hold 0, counters 0, bus_rd_data 0.
- Assembler FSM:
  - EMPTY: on valid&ready, latch lo <= bus_wr_data, go to HALF.
  - HALF: on valid&ready, latch hi, go to PEND.
  - PEND: when !inst_fifo_full, assert inst_fifo_wr_en for 1 cycle with wr_data = {lo, hi}, inst_count+1, go to EMPTY.
  - The first bus word is instruction[31:0] but lands in wr_data MSBs, because the FIFO presents MSB-first and the sequencer swaps halves.
- Push latency: 1 cycle after the second word if the FIFO is not full.
- bus_wr_ready = (state != PEND), combinational from the state register.
  - A write on the cycle of the push is stalled.
  - Max throughput: one instruction per 3 cycles.
- FIFO full in PEND: hold state, keep wr_en 0, and assert pulse_controller_release for 1 cycle on entry to the full condition (rising edge of full while in PEND). This starts a held sequence so the FIFO drains.
- half_pending = (state == HALF).
- Control writes (one cycle):
  - set_hold: hold <= 1.
  - clr_hold: hold <= 0. set_hold and clr_hold both set: clr wins.
  - release: 1-cycle release pulse.
  - init: 1-cycle init pulse; also discards any partial or pending word (state EMPTY, no push) and zeroes inst_count.
  - An init coincident with a second-word write drops that word.
  - release and init in the same ctrl_data are both issued in the same cycle.
- Result read path:
  - bus_rd_req with !result_fifo_empty: rd_en=1; next cycle bus_rd_data <= result_fifo_rd_data, bus_rd_valid=1.
  - bus_rd_req with result_fifo_empty: no pop; next cycle bus_rd_valid=1, bus_rd_data=0xFFFFFFFF (empty marker).
  - Only one read is outstanding. A bus_rd_req in the valid cycle is accepted normally (back-to-back reads are allowed).
- inst_count wraps modulo 2^CNT_WIDTH.

Optional Feature:
- Macro INST_FIFO_WRITER_STATS_EN.
- When defined, add output stall_cycles (CNT_WIDTH):
  - Counts cycles in PEND with inst_fifo_full=1.
  - Saturates at all-ones.
  - Cleared by reset and init.
- When undefined: the port is absent and no counter logic is built.

Test Plan:
- Write 0x11111111 then 0x22222222, FIFO not full -> one wr_en pulse 1 cycle after the 2nd write; wr_data=0x1111111122222222; inst_count=1; bus_wr_ready low exactly 1 cycle.
- inst_fifo_full=1 before the 2nd write -> no push, bus_wr_ready=0, single release pulse; drop full after 10 cycles -> push next cycle, stall_cycles=10 (stats build).
- Write one half (0xAAAA0000), then ctrl init (0x8) -> init pulse 1 cycle, half_pending 0, no push; next pair pushes normally.
- ctrl 0x1, then ctrl 0x3 -> hold=1 then hold=0.
- Result FIFO holds 0xDEADBEEF and 0x5: two back-to-back bus_rd_req -> bus_rd_valid on cycles +1 and +2 with those values; a third read when empty -> 0xFFFFFFFF, no rd_en.
- Assert reset mid-PEND with the FIFO full -> all outputs at reset values immediately, no push after reset releases.
